// File: rtl/adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package adder_ctrl_pkg;

    localparam int unsigned NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } adder_state_t;

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit ripple-carry slice shared by the serial adder controller.
module nibble_adder
    import adder_ctrl_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              cin,
    output logic [NIBBLE-1:0] sum,
    output logic              cout
);

    always_comb begin
        logic [NIBBLE:0] c;
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < NIBBLE; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[NIBBLE];
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a shared 4-bit slice.
// Optional macro SUB_EN adds the sub port (a - b via a + ~b + 1).
module nibble_serial_adder_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NSLICE = WIDTH / NIBBLE;
    localparam int unsigned CNTW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned SHW    = CNTW + $clog2(NIBBLE);

    adder_state_t     state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic              op_sub;
    logic [SHW-1:0]    sh;
    logic [NIBBLE-1:0] sl_a, sl_b, sl_s;
    logic              sl_c;

`ifdef SUB_EN
    assign op_sub = sub;
`else
    assign op_sub = 1'b0;
`endif

    // Bit offset of the nibble currently being processed.
    assign sh   = SHW'(cnt_q) << $clog2(NIBBLE);
    assign sl_a = NIBBLE'(a_q >> sh);
    assign sl_b = NIBBLE'(b_q >> sh);

    nibble_adder u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sum  (sl_s),
        .cout (sl_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub ? 1'b1 : cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = (sum_q & ~(WIDTH'({NIBBLE{1'b1}}) << sh)) | (WIDTH'(sl_s) << sh);
                carry_d = sl_c;
                if (cnt_q == CNTW'(NSLICE - 1)) begin
                    cout_d  = sl_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flags registered alongside the state they describe.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16); honours SUB_EN.
module tb_nibble_serial_adder_ctrl;

    localparam int unsigned W  = 16;
    localparam int unsigned NS = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         sub;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full operation; glitch = sample index (after acceptance) at which a stray start is driven, -1 for none.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                          input logic tsub, input int glitch);
        int unsigned  r;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        int           lat;
        int           busy_cnt;
        int           done_cnt;

        r        = int'(ta) + (tsub ? (32'hFFFF - int'(tb)) : int'(tb)) + (tsub ? 1 : int'(tcin));
        exp_sum  = W'(r);
        exp_cout = r[W];

        a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
        step();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        chk("acc_sum_clr", 32'(sum), 32'h0);

        lat = -1; busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                lat = k;
                done_cnt++;
                break;
            end
            if (k == glitch) begin
                start = 1'b1;
                a     = 16'hAAAA;
            end
            step();
            start = 1'b0;
        end
        chk("latency", 32'(lat), 32'(NS));
        chk("busy_cycles", 32'(busy_cnt), 32'(NS + 1));
        chk("sum", 32'(sum), 32'(exp_sum));
        chk("cout", 32'(cout), 32'(exp_cout));

        if (glitch == int'(NS)) begin
            start = 1'b1;
            a     = 16'hAAAA;
        end
        step();
        start = 1'b0;
        if (done === 1'b1) done_cnt++;
        chk("done_pulses", 32'(done_cnt), 32'h1);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("sum_held", 32'(sum), 32'(exp_sum));
        chk("cout_held", 32'(cout), 32'(exp_cout));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_sum",  32'(sum),  32'h0);
        chk("rst_cout", 32'(cout), 32'h0);
        rst = 1'b0;
        step();
        chk("post_rst_busy", 32'(busy), 32'h0);

        // Carry ripples through every nibble.
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, -1);
        // Carry-in honoured.
        run_op(16'h1234, 16'h4321, 1'b1, 1'b0, -1);
        // Stray start during RUN and during DONE are ignored.
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1);
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, int'(NS));
        // Back-to-back start the cycle after done.
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, -1);

        // Reset in the third RUN cycle aborts the operation.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_sum",  32'(sum),  32'h0);
        chk("abort_done", 32'(done), 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_no_done", 32'(done), 32'h0);
        end
        run_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0, -1);

`ifdef SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, -1);
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, -1);
        run_op(16'h1234, 16'h1234, 1'b0, 1'b1, -1);
`endif

        // Randomized operations, with random idle gaps checking the hold behaviour.
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra, rb;
            logic         rc, rs;
            logic [W-1:0] held;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, rc, rs, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NS)) : -1);
            held = sum;
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                step();
                chk("gap_sum_held", 32'(sum), 32'(held));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
